// File: rtl/traffic_light_controller.sv
// ---------------------------------------------------------------------------
// traffic_light_controller
//
// Phase sequencer for a main-road / side-road intersection with a pedestrian
// crossing. An external down-counter serves as the dwell timer. On every phase
// entry the controller loads that counter with the phase duration. It then lets
// the counter run down on timebase ticks and advances the phase once the
// counter reports zero.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous, active-high reset
//   tick         timebase enable; the dwell counter only moves when tick=1
//   side_req     side-road vehicle sensor (level or pulse)
//   ped_req      pedestrian push button (level or pulse)
//   flash_mode   request for flashing-yellow maintenance mode
//   cnt_zero     zero flag of the external counter
//   cnt_load     parallel-load strobe for the counter
//   cnt_en       counter enable
//   cnt_dir      counter direction, tied to 1 (down)
//   cnt_value    counter load value (duration of the current phase)
//   main_light   {red,yellow,green} for the main road
//   side_light   {red,yellow,green} for the side road
//   ped_walk     pedestrian walk lamp
//   state_o      current phase code, for debug
// ---------------------------------------------------------------------------
module traffic_light_controller #(
    parameter int N            = 11,
    parameter int T_MAIN_GREEN = 20,
    parameter int T_SIDE_GREEN = 10,
    parameter int T_YELLOW     = 3,
    parameter int T_ALL_RED    = 1,
    parameter int T_FLASH      = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic         side_req,
    input  logic         ped_req,
    input  logic         flash_mode,
    input  logic         cnt_zero,
    output logic         cnt_load,
    output logic         cnt_en,
    output logic         cnt_dir,
    output logic [N-1:0] cnt_value,
    output logic [2:0]   main_light,
    output logic [2:0]   side_light,
    output logic         ped_walk,
    output logic [2:0]   state_o
);

    localparam logic [2:0] ALL_RED_2   = 3'd0;
    localparam logic [2:0] MAIN_GREEN  = 3'd1;
    localparam logic [2:0] MAIN_YELLOW = 3'd2;
    localparam logic [2:0] ALL_RED_1   = 3'd3;
    localparam logic [2:0] SIDE_GREEN  = 3'd4;
    localparam logic [2:0] SIDE_YELLOW = 3'd5;
    localparam logic [2:0] FLASH       = 3'd6;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    logic [2:0] state_r;
    logic [2:0] state_next_s;
    logic       first_r;
    logic       reload_s;
    logic       expiry_s;
    logic       flash_toggle_s;
    logic       side_pend_r;
    logic       ped_pend_r;
    logic       flash_ph_r;
    logic       ped_srv_r;
    logic       sg_entry_s;

    // Dwell time loaded into the counter for each phase
    function automatic logic [N-1:0] phase_duration(input logic [2:0] s);
        case (s)
            MAIN_GREEN:  return N'(T_MAIN_GREEN);
            MAIN_YELLOW: return N'(T_YELLOW);
            SIDE_GREEN:  return N'(T_SIDE_GREEN);
            SIDE_YELLOW: return N'(T_YELLOW);
            FLASH:       return N'(T_FLASH);
            default:     return N'(T_ALL_RED);
        endcase
    endfunction

    // The zero flag is stale in the load cycle, so it only counts once the
    // freshly loaded value has reached the counter.
    assign expiry_s   = ~first_r & cnt_zero;
    assign sg_entry_s = first_r & (state_r == SIDE_GREEN);

    // Next-phase decision; reload_s marks every phase entry, including the
    // flash half-period restart.
    always_comb begin
        state_next_s   = state_r;
        reload_s       = 1'b0;
        flash_toggle_s = 1'b0;
        case (state_r)
            ALL_RED_2: begin
                if (expiry_s) begin
                    state_next_s = MAIN_GREEN;
                    reload_s     = 1'b1;
                end else begin
                    state_next_s = ALL_RED_2;
                end
            end
            MAIN_GREEN: begin
                // Without a pending demand the main road keeps green with the
                // counter parked at zero.
                if (expiry_s && (side_pend_r || ped_pend_r || flash_mode)) begin
                    state_next_s = MAIN_YELLOW;
                    reload_s     = 1'b1;
                end else begin
                    state_next_s = MAIN_GREEN;
                end
            end
            MAIN_YELLOW: begin
                if (expiry_s) begin
                    state_next_s = ALL_RED_1;
                    reload_s     = 1'b1;
                end else begin
                    state_next_s = MAIN_YELLOW;
                end
            end
            ALL_RED_1: begin
                if (expiry_s) begin
                    state_next_s = flash_mode ? FLASH : SIDE_GREEN;
                    reload_s     = 1'b1;
                end else begin
                    state_next_s = ALL_RED_1;
                end
            end
            SIDE_GREEN: begin
                if (expiry_s) begin
                    state_next_s = SIDE_YELLOW;
                    reload_s     = 1'b1;
                end else begin
                    state_next_s = SIDE_GREEN;
                end
            end
            SIDE_YELLOW: begin
                if (expiry_s) begin
                    state_next_s = ALL_RED_2;
                    reload_s     = 1'b1;
                end else begin
                    state_next_s = SIDE_YELLOW;
                end
            end
            FLASH: begin
                if (expiry_s) begin
                    reload_s = 1'b1;
                    if (flash_mode) begin
                        state_next_s   = FLASH;
                        flash_toggle_s = 1'b1;
                    end else begin
                        state_next_s = ALL_RED_2;
                    end
                end else begin
                    state_next_s = FLASH;
                end
            end
            default: begin
                state_next_s = ALL_RED_2;
                reload_s     = 1'b1;
            end
        endcase
    end

    // Phase register and entry flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ALL_RED_2;
            first_r <= 1'b1;
        end else begin
            state_r <= state_next_s;
            first_r <= reload_s;
        end
    end

    // Demand latches; they are consumed in the first side-green cycle, and a
    // request landing in that cycle is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            side_pend_r <= 1'b0;
            ped_pend_r  <= 1'b0;
        end else if (sg_entry_s) begin
            side_pend_r <= 1'b0;
            ped_pend_r  <= 1'b0;
        end else begin
            side_pend_r <= side_pend_r | side_req;
            ped_pend_r  <= ped_pend_r | ped_req;
        end
    end

    // Walk service capture and flash half-period phase. ped_srv_r takes the
    // value ped_pend_r will hold during the side-green entry cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ped_srv_r  <= 1'b0;
            flash_ph_r <= 1'b0;
        end else begin
            if (reload_s && (state_next_s == SIDE_GREEN)) begin
                ped_srv_r <= ped_pend_r | ped_req;
            end else begin
                ped_srv_r <= ped_srv_r;
            end
            if (flash_toggle_s) begin
                flash_ph_r <= ~flash_ph_r;
            end else begin
                flash_ph_r <= flash_ph_r;
            end
        end
    end

    // Lamp decode from the current phase
    always_comb begin
        main_light = LAMP_RED;
        side_light = LAMP_RED;
        case (state_r)
            MAIN_GREEN:  main_light = LAMP_GREEN;
            MAIN_YELLOW: main_light = LAMP_YELLOW;
            SIDE_GREEN:  side_light = LAMP_GREEN;
            SIDE_YELLOW: side_light = LAMP_YELLOW;
            FLASH: begin
                main_light = {1'b0, flash_ph_r, 1'b0};
                side_light = {1'b0, flash_ph_r, 1'b0};
            end
            default: begin
                main_light = LAMP_RED;
                side_light = LAMP_RED;
            end
        endcase
    end

    assign ped_walk  = (state_r == SIDE_GREEN) & ped_srv_r;
    assign cnt_load  = first_r;
    // Gating on cnt_zero keeps the counter from wrapping below zero.
    assign cnt_en    = ~first_r & tick & ~cnt_zero;
    assign cnt_dir   = 1'b1;
    assign cnt_value = phase_duration(state_r);
    assign state_o   = state_r;

endmodule

// File: tb/tb_traffic_light_controller.sv
// ---------------------------------------------------------------------------
// Bench for traffic_light_controller. It emulates the external dwell counter.
// A phase/age/tick-count reference model predicts every cycle's outputs and
// queues them, and a forked monitor pops and compares at the falling edge.
// ---------------------------------------------------------------------------
module tb_traffic_light_controller;

    localparam int D_MG = 20;
    localparam int D_SG = 10;
    localparam int D_Y  = 3;
    localparam int D_AR = 1;
    localparam int D_FL = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        side_req = 1'b0;
    logic        ped_req = 1'b0;
    logic        flash_mode = 1'b0;
    logic        cnt_zero;
    logic        cnt_load;
    logic        cnt_en;
    logic        cnt_dir;
    logic [10:0] cnt_value;
    logic [2:0]  main_light;
    logic [2:0]  side_light;
    logic        ped_walk;
    logic [2:0]  state_o;

    traffic_light_controller dut (
        .clk(clk), .rst(rst), .tick(tick), .side_req(side_req),
        .ped_req(ped_req), .flash_mode(flash_mode), .cnt_zero(cnt_zero),
        .cnt_load(cnt_load), .cnt_en(cnt_en), .cnt_dir(cnt_dir),
        .cnt_value(cnt_value), .main_light(main_light),
        .side_light(side_light), .ped_walk(ped_walk), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // External up/down load counter
    logic [10:0] cnt_q;
    always @(posedge clk) begin
        if (cnt_load) cnt_q <= cnt_value;
        else if (cnt_en) cnt_q <= cnt_dir ? cnt_q - 11'd1 : cnt_q + 11'd1;
    end
    assign cnt_zero = (cnt_q == 11'd0);

    typedef struct {
        logic        load;
        logic        en;
        logic [10:0] value;
        logic [2:0]  main_l;
        logic [2:0]  side_l;
        logic        walk;
        logic [2:0]  st;
    } exp_t;

    exp_t       exp_q[$];
    logic [2:0] st_log[$];
    logic       walk_log[$];
    int total = 0;
    int bad = 0;

    // Reference model state: phase code, cycles since entry, ticks counted
    int m_ph, m_age, m_ticks;
    bit m_sp, m_pp, m_fl, m_srv;

    function automatic int dur(input int ph);
        case (ph)
            1: return D_MG;
            2: return D_Y;
            4: return D_SG;
            5: return D_Y;
            6: return D_FL;
            default: return D_AR;
        endcase
    endfunction

    function automatic logic [2:0] lamp_main(input int ph, input bit fl);
        case (ph)
            1: return 3'b001;
            2: return 3'b010;
            6: return {1'b0, fl, 1'b0};
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] lamp_side(input int ph, input bit fl);
        case (ph)
            4: return 3'b001;
            5: return 3'b010;
            6: return {1'b0, fl, 1'b0};
            default: return 3'b100;
        endcase
    endfunction

    task automatic model_reset();
        m_ph = 0; m_age = 0; m_ticks = 0;
        m_sp = 0; m_pp = 0; m_fl = 0; m_srv = 0;
    endtask

    // Advance the model across one clock edge using the current inputs
    task automatic model_advance(input bit zero_now, input bit en);
        int nxt;
        bit enter;
        if (rst) begin
            model_reset();
            return;
        end
        nxt = m_ph;
        enter = 0;
        if (m_age != 0 && zero_now) begin
            case (m_ph)
                0: nxt = 1;
                1: if (m_sp || m_pp || flash_mode) nxt = 2;
                2: nxt = 3;
                3: nxt = flash_mode ? 6 : 4;
                4: nxt = 5;
                5: nxt = 0;
                6: begin
                    enter = 1;
                    if (flash_mode) m_fl = !m_fl;
                    else nxt = 0;
                end
                default: nxt = 0;
            endcase
        end
        if (nxt != m_ph) enter = 1;
        if (enter && nxt == 4) m_srv = m_pp || ped_req;
        if (m_ph == 4 && m_age == 0) begin
            m_sp = 0; m_pp = 0;
        end else begin
            m_sp = m_sp || side_req; m_pp = m_pp || ped_req;
        end
        if (enter) begin
            m_ph = nxt; m_age = 0; m_ticks = 0;
        end else begin
            m_age = m_age + 1;
            m_ticks = m_ticks + int'(en);
        end
    endtask

    // One cycle: predict outputs for the applied inputs, queue them, clock
    task automatic step();
        exp_t e;
        bit zero_now;
        int d;
        d = dur(m_ph);
        zero_now = (m_ticks >= d);
        e.load   = (m_age == 0);
        e.en     = (m_age != 0) && tick && !zero_now;
        e.value  = 11'(d);
        e.main_l = lamp_main(m_ph, m_fl);
        e.side_l = lamp_side(m_ph, m_fl);
        e.walk   = (m_ph == 4) && m_srv;
        e.st     = 3'(m_ph);
        exp_q.push_back(e);
        model_advance(zero_now, e.en);
        @(posedge clk);
        #1;
    endtask

    task automatic check_int(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // Steps until the model has just entered phase ph (at least one step)
    task automatic run_until_enter(input int ph, input int budget);
        int n = 0;
        do begin
            step();
            n++;
        end while (!(m_ph == ph && m_age == 0) && n < budget);
        if (!(m_ph == ph && m_age == 0)) begin
            total++; bad++;
            $display("FAIL wait_phase_%0d: timeout after %0d cycles", ph, n);
        end
    endtask

    function automatic int run_len(input logic [2:0] code);
        int n = 0;
        bit done = 0;
        for (int i = 0; i < st_log.size(); i++) begin
            if (!done) begin
                if (st_log[i] == code) n++;
                else if (n > 0) done = 1;
            end
        end
        return n;
    endfunction

    function automatic int walk_count();
        int n = 0;
        for (int i = 0; i < walk_log.size(); i++) n += int'(walk_log[i]);
        return n;
    endfunction

    task automatic monitor_loop();
        exp_t e;
        bit ok;
        forever begin
            @(negedge clk);
            st_log.push_back(state_o);
            walk_log.push_back(ped_walk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                ok = (cnt_load == e.load) && (cnt_en == e.en) && (cnt_dir == 1'b1) &&
                     (main_light == e.main_l) && (side_light == e.side_l) &&
                     (ped_walk == e.walk) && (state_o == e.st) &&
                     (!e.load || cnt_value == e.value);
                total++;
                if (!ok) begin
                    bad++;
                    $display("FAIL cycle_outputs @%0t: got st=%0d ld=%b en=%b dir=%b val=%0d main=%b side=%b walk=%b required st=%0d ld=%b en=%b dir=1 val=%0d main=%b side=%b walk=%b",
                             $time, state_o, cnt_load, cnt_en, cnt_dir, cnt_value, main_light, side_light, ped_walk,
                             e.st, e.load, e.en, e.value, e.main_l, e.side_l, e.walk);
                end
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int d;
        fork
            monitor_loop();
        join_none
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;

        // Reset, then idle main green
        tick = 1'b1;
        do_reset();
        st_log.delete();
        run_until_enter(1, 50);
        check_int("reset_all_red_dwell", run_len(3'd0), 3);
        st_log.delete();
        repeat (40) step();
        check_int("main_green_hold", run_len(3'd1), 40);

        // Side request 5 cycles into a fresh main green
        do_reset();
        run_until_enter(1, 50);
        st_log.delete();
        walk_log.delete();
        repeat (5) step();
        side_req = 1'b1; step(); side_req = 1'b0;
        run_until_enter(1, 200);
        check_int("mg_dwell", run_len(3'd1), 22);
        check_int("my_dwell", run_len(3'd2), 5);
        check_int("ar1_dwell", run_len(3'd3), 3);
        check_int("sg_dwell", run_len(3'd4), 12);
        check_int("sy_dwell", run_len(3'd5), 5);
        check_int("ar2_dwell", run_len(3'd0), 3);
        check_int("no_walk", walk_count(), 0);

        // Pedestrian during yellow, second press during side green
        walk_log.delete();
        side_req = 1'b1; step(); side_req = 1'b0;
        run_until_enter(2, 200);
        repeat (2) step();
        ped_req = 1'b1; step(); ped_req = 1'b0;
        run_until_enter(4, 100);
        repeat (4) step();
        ped_req = 1'b1; step(); ped_req = 1'b0;
        run_until_enter(1, 200);
        run_until_enter(1, 200);
        check_int("walk_cycles", walk_count(), 24);

        // Flash mode entered from main green, then released
        flash_mode = 1'b1;
        run_until_enter(6, 200);
        repeat (30) step();
        flash_mode = 1'b0;
        run_until_enter(1, 50);
        repeat (3) step();

        // Tick gating: one tick every fourth cycle
        st_log.delete();
        for (int i = 0; i < 400; i++) begin
            tick = (i % 4 == 3);
            side_req = (i == 0);
            step();
        end
        side_req = 1'b0;
        d = run_len(3'd2);
        check_int("gated_yellow_dwell_in_11_14", int'(d >= 11 && d <= 14), 1);

        // Reset in the middle of side green with fresh demands latched
        tick = 1'b1;
        side_req = 1'b1; step(); side_req = 1'b0;
        run_until_enter(4, 300);
        repeat (3) step();
        side_req = 1'b1; ped_req = 1'b1; step();
        side_req = 1'b0; ped_req = 1'b0;
        rst = 1'b1; step(); rst = 1'b0;
        st_log.delete();
        run_until_enter(1, 50);
        check_int("post_rst_state", int'(st_log[0]), 0);
        check_int("post_rst_ar2_dwell", run_len(3'd0), 3);
        st_log.delete();
        repeat (30) step();
        check_int("post_rst_latches_clear", run_len(3'd1), 30);

        // Randomised traffic
        for (int i = 0; i < 2500; i++) begin
            tick = 1'($urandom_range(0, 1));
            side_req = ($urandom_range(0, 31) == 0);
            ped_req = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 199) == 0) flash_mode = ~flash_mode;
            rst = ($urandom_range(0, 399) == 0);
            step();
        end
        rst = 1'b0;
        step();

        check_int("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
